// File: rtl/first_nios2_system_pkg.sv
// Shared types and constants for the first_nios2_system sysid checker:
// the checker FSM state encoding and the system-ID slave word offsets.
package first_nios2_system_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    CAP_ID,
    REQ_TS,
    CAP_TS,
    FINISH
  } sysid_state_e;

  localparam logic SYSID_OFS_ID = 1'b0;
  localparam logic SYSID_OFS_TS = 1'b1;

  // Latency counter covers READ_LATENCY up to 3; stall counter covers TIMEOUT_CYCLES up to 65535.
  localparam int LAT_CNT_W   = 2;
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/first_nios2_system_avm_single_read.sv
// Mechanics of a single Avalon-MM read: acceptance, fixed read latency and
// stall timeout. The owning FSM says when a request or capture phase is active.
module first_nios2_system_avm_single_read
  import first_nios2_system_pkg::*;
#(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic req_active,
  input  logic cap_active,
  input  logic avm_waitrequest,
  output logic accept,
  output logic sample,
  output logic expired
);

  localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_CNT_W-1:0]   LAT_LAST   =
    LAT_CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [LAT_CNT_W-1:0]   lat_cnt;

  // stall_cnt holds the number of stalled cycles already seen, so the limit is hit on the last one.
  assign accept  = req_active && !avm_waitrequest;
  assign expired = req_active && avm_waitrequest && (stall_cnt == STALL_LAST);
  assign sample  = (READ_LATENCY == 0) ? accept : (cap_active && (lat_cnt == LAT_LAST));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      lat_cnt   <= '0;
    end else begin
      if (!req_active || accept || expired) begin
        stall_cnt <= '0;
      end else if (avm_waitrequest) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (cap_active && !sample) begin
        lat_cnt <= lat_cnt + 1'b1;
      end else begin
        lat_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Reads the system ID and build timestamp from the sysid slave after a start
// pulse and reports whether they match the values expected for this image.
module first_nios2_system_sysid_checker
  import first_nios2_system_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd7,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1382561209,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e state;
  sysid_state_e state_next;

  logic req_active;
  logic cap_active;
  logic reading_ts;
  logic accept;
  logic sample;
  logic expired;

  assign req_active = (state == REQ_ID) || (state == REQ_TS);
  assign cap_active = (state == CAP_ID) || (state == CAP_TS);
  assign reading_ts = (state == REQ_TS) || (state == CAP_TS);

  first_nios2_system_avm_single_read #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_read (
    .clock          (clock),
    .reset          (reset),
    .req_active     (req_active),
    .cap_active     (cap_active),
    .avm_waitrequest(avm_waitrequest),
    .accept         (accept),
    .sample         (sample),
    .expired        (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus outputs depend on state only, so a reset drops avm_read without waiting for a clock.
  always_comb begin
    state_next  = state;
    avm_read    = req_active;
    avm_address = reading_ts ? SYSID_OFS_TS : SYSID_OFS_ID;
    busy        = req_active || cap_active;
    done        = (state == FINISH);

    case (state)
      IDLE: begin
        if (start) state_next = REQ_ID;
      end
      REQ_ID: begin
        if (expired)     state_next = FINISH;
        else if (accept) state_next = (READ_LATENCY == 0) ? REQ_TS : CAP_ID;
      end
      CAP_ID: begin
        if (sample) state_next = REQ_TS;
      end
      REQ_TS: begin
        if (expired)     state_next = FINISH;
        else if (accept) state_next = (READ_LATENCY == 0) ? FINISH : CAP_TS;
      end
      CAP_TS: begin
        if (sample) state_next = FINISH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Results are cleared only by an accepted start, so they survive until the next check.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else if ((state == IDLE) && start) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (sample && !reading_ts) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (sample && reading_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (expired) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Bench for the sysid checker: two instances (read latency 0 and 2) share the
// stimulus; each has its own slave and a transaction-level timeline model.
module tb_first_nios2_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd7;
  localparam logic [31:0] EXP_TS = 32'd1382561209;
  localparam int          TMO    = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          stall0;
  int          stall1;
  logic [31:0] data0;
  logic [31:0] data1;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input int g,
                              input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s (inst %0d, cycle %0d): got 0x%0h, expected 0x%0h",
               name, g, cyc, actual, expected);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = 2 * g;

    logic        avm_read, avm_address, avm_waitrequest;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] avm_readdata, id_value, ts_value;

    bit          has_seq = 1'b0;
    bit          to_seq  = 1'b0;
    int          s_cyc, rd0_hi, rd1_lo, rd1_hi, samp0, samp1, fin;
    logic [31:0] md0, md1;
    int          done_cnt = 0;

    int          sl_cnt;
    int          sl_pend;
    logic [31:0] sl_pdat;

    bit          e_rd, e_addr, e_busy, e_done, e_idok, e_tsok, e_to;
    logic [31:0] e_idv, e_tsv;

    first_nios2_system_sysid_checker #(
      .EXPECTED_ID       (EXP_ID),
      .EXPECTED_TIMESTAMP(EXP_TS),
      .READ_LATENCY      (LAT),
      .TIMEOUT_CYCLES    (TMO)
    ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata   (avm_readdata),
      .busy           (busy),
      .done           (done),
      .id_ok          (id_ok),
      .ts_ok          (ts_ok),
      .timeout        (timeout),
      .id_value       (id_value),
      .ts_value       (ts_value)
    );

    // On an accepted start, lay out the whole sequence as cycle numbers.
    always @(posedge clock or posedge reset) begin
      if (reset) begin
        has_seq = 1'b0;
      end else if (start && (!has_seq || cyc > fin)) begin
        has_seq = 1'b1;
        s_cyc   = cyc;
        md0     = data0;
        md1     = data1;
        samp0   = -1;
        samp1   = -1;
        rd1_lo  = 1;
        rd1_hi  = 0;
        if (stall0 >= TMO) begin
          rd0_hi = cyc + TMO;
          fin    = cyc + TMO + 1;
          to_seq = 1'b1;
        end else begin
          rd0_hi = cyc + 1 + stall0;
          samp0  = rd0_hi + LAT;
          rd1_lo = samp0 + 1;
          if (stall1 >= TMO) begin
            rd1_hi = rd1_lo + TMO - 1;
            fin    = rd1_lo + TMO;
            to_seq = 1'b1;
          end else begin
            rd1_hi = rd1_lo + stall1;
            samp1  = rd1_hi + LAT;
            fin    = samp1 + 1;
            to_seq = 1'b0;
          end
        end
      end
    end

    // Slave: stall each read by the configured count, return data LAT cycles after acceptance.
    initial begin
      sl_cnt          = 0;
      sl_pend         = -1;
      sl_pdat         = '0;
      avm_waitrequest = 1'b0;
      avm_readdata    = '0;
      forever begin
        @(negedge clock);
        if (reset) begin
          sl_cnt          = 0;
          sl_pend         = -1;
          avm_waitrequest = 1'b0;
          avm_readdata    = '0;
        end else begin
          avm_waitrequest = 1'b0;
          if (avm_read) begin
            if (sl_cnt < (avm_address ? stall1 : stall0)) begin
              avm_waitrequest = 1'b1;
              sl_cnt++;
            end else begin
              sl_cnt  = 0;
              sl_pend = cyc + LAT;
              sl_pdat = avm_address ? data1 : data0;
            end
          end else begin
            sl_cnt = 0;
          end
          avm_readdata = (cyc == sl_pend) ? sl_pdat : $urandom;
        end
      end
    end

    initial begin
      forever begin
        @(negedge clock);
        e_rd   = 1'b0;
        e_addr = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_idok = 1'b0;
        e_tsok = 1'b0;
        e_to   = 1'b0;
        e_idv  = '0;
        e_tsv  = '0;
        if (!reset && has_seq) begin
          e_addr = (cyc >= rd1_lo) && (cyc <= rd1_hi);
          e_rd   = ((cyc > s_cyc) && (cyc <= rd0_hi)) || e_addr;
          e_busy = (cyc > s_cyc) && (cyc < fin);
          e_done = (cyc == fin);
          e_to   = to_seq && (cyc >= fin);
          if (samp0 >= 0 && cyc > samp0) begin
            e_idv  = md0;
            e_idok = (md0 == EXP_ID);
          end
          if (samp1 >= 0 && cyc > samp1) begin
            e_tsv  = md1;
            e_tsok = (md1 == EXP_TS);
          end
        end
        if (done) done_cnt++;
        check_output("avm_read", g, 32'(avm_read), 32'(e_rd));
        check_output("busy",     g, 32'(busy),     32'(e_busy));
        check_output("done",     g, 32'(done),     32'(e_done));
        check_output("id_ok",    g, 32'(id_ok),    32'(e_idok));
        check_output("ts_ok",    g, 32'(ts_ok),    32'(e_tsok));
        check_output("timeout",  g, 32'(timeout),  32'(e_to));
        check_output("id_value", g, id_value,      e_idv);
        check_output("ts_value", g, ts_value,      e_tsv);
        if (e_rd && avm_read) check_output("avm_address", g, 32'(avm_address), 32'(e_addr));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Leaves the caller at the falling edge of cycle c.
  task automatic goto_cycle(input int c);
    while (cyc < c) step(1);
    @(negedge clock);
  endtask

  task automatic apply_stimulus(output int s);
    @(posedge clock);
    #1;
    start = 1'b1;
    s     = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 400;
    @(posedge clock);
    #1;
    while (budget > 0 && !((!inst[0].has_seq || cyc > inst[0].fin) &&
                           (!inst[1].has_seq || cyc > inst[1].fin) &&
                           !inst[0].busy && !inst[1].busy)) begin
      step(1);
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fail++;
      $display("[TB] FAIL idle_wait: got still busy at cycle %0d, expected idle", cyc);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int dc0;
    int dc1;
    reset  = 1'b1;
    start  = 1'b0;
    stall0 = 0;
    stall1 = 0;
    data0  = EXP_ID;
    data1  = EXP_TS;
    step(2);
    @(negedge clock);
    check_output("reset_busy",     0, 32'(inst[0].busy),     32'd0);
    check_output("reset_avm_read", 0, 32'(inst[0].avm_read), 32'd0);
    check_output("reset_id_value", 0, inst[0].id_value,      32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(2);

    $display("[TB] matching image, zero-wait slave");
    apply_stimulus(s);
    goto_cycle(s + 2);
    check_output("t1_done_early", 0, 32'(inst[0].done), 32'd0);
    goto_cycle(s + 3);
    check_output("t1_done", 0, 32'(inst[0].done), 32'd1);
    goto_cycle(s + 4);
    check_output("t1_id_ok",   0, 32'(inst[0].id_ok),   32'd1);
    check_output("t1_ts_ok",   0, 32'(inst[0].ts_ok),   32'd1);
    check_output("t1_timeout", 0, 32'(inst[0].timeout), 32'd0);
    goto_cycle(s + 7);
    check_output("t1_done_lat2", 1, 32'(inst[1].done), 32'd1);
    wait_idle();

    $display("[TB] wrong system ID");
    data0 = 32'd8;
    dc0   = inst[0].done_cnt;
    apply_stimulus(s);
    goto_cycle(s + 4);
    check_output("t2_id_ok",    0, 32'(inst[0].id_ok), 32'd0);
    check_output("t2_ts_ok",    0, 32'(inst[0].ts_ok), 32'd1);
    check_output("t2_id_value", 0, inst[0].id_value,   32'd8);
    wait_idle();
    check_output("t2_done_pulses", 0, 32'(inst[0].done_cnt - dc0), 32'd1);
    data0 = EXP_ID;

    $display("[TB] stalled slave");
    stall0 = 5;
    stall1 = 5;
    apply_stimulus(s);
    goto_cycle(s + 8);
    check_output("t3_id_before_sample", 1, inst[1].id_value, 32'd0);
    goto_cycle(s + 9);
    check_output("t3_id_after_sample", 1, inst[1].id_value, 32'd7);
    goto_cycle(s + 17);
    check_output("t3_done",  1, 32'(inst[1].done),  32'd1);
    check_output("t3_id_ok", 1, 32'(inst[1].id_ok), 32'd1);
    check_output("t3_ts_ok", 1, 32'(inst[1].ts_ok), 32'd1);
    wait_idle();

    $display("[TB] stuck waitrequest");
    stall0 = 1000;
    stall1 = 0;
    apply_stimulus(s);
    goto_cycle(s + 16);
    check_output("t4_read_last", 0, 32'(inst[0].avm_read), 32'd1);
    goto_cycle(s + 17);
    check_output("t4_read_drop", 0, 32'(inst[0].avm_read), 32'd0);
    check_output("t4_done",      0, 32'(inst[0].done),     32'd1);
    check_output("t4_timeout",   0, 32'(inst[0].timeout),  32'd1);
    check_output("t4_ts_ok",     0, 32'(inst[0].ts_ok),    32'd0);
    wait_idle();
    stall0 = 0;

    $display("[TB] start re-pulsed while busy and in the finish cycle");
    dc0 = inst[0].done_cnt;
    dc1 = inst[1].done_cnt;
    apply_stimulus(s);
    step(1);
    start = 1'b1;
    step(2);
    start = 1'b0;
    wait_idle();
    check_output("t5_done_pulses", 0, 32'(inst[0].done_cnt - dc0), 32'd1);
    check_output("t5_done_pulses", 1, 32'(inst[1].done_cnt - dc1), 32'd1);

    $display("[TB] reset during timestamp read");
    stall1 = 5;
    apply_stimulus(s);
    step(3);
    #2;
    reset = 1'b1;
    #1;
    check_output("t6_avm_read", 0, 32'(inst[0].avm_read), 32'd0);
    check_output("t6_busy",     0, 32'(inst[0].busy),     32'd0);
    check_output("t6_id_value", 0, inst[0].id_value,      32'd0);
    check_output("t6_id_ok",    0, 32'(inst[0].id_ok),    32'd0);
    check_output("t6_avm_read", 1, 32'(inst[1].avm_read), 32'd0);
    step(2);
    reset  = 1'b0;
    stall1 = 0;
    step(1);
    apply_stimulus(s);
    wait_idle();
    check_output("t6_clean_id_ok",   0, 32'(inst[0].id_ok),   32'd1);
    check_output("t6_clean_ts_ok",   0, 32'(inst[0].ts_ok),   32'd1);
    check_output("t6_clean_timeout", 1, 32'(inst[1].timeout), 32'd0);

    $display("[TB] randomized sequences");
    for (int i = 0; i < 40; i++) begin
      stall0 = $urandom_range(0, 20);
      stall1 = $urandom_range(0, 20);
      data0  = ($urandom_range(0, 1) == 1) ? EXP_ID : 32'($urandom);
      data1  = ($urandom_range(0, 1) == 1) ? EXP_TS : 32'($urandom);
      apply_stimulus(s);
      if ($urandom_range(0, 1) == 1) begin
        step($urandom_range(0, 6));
        start = 1'b1;
        step(1);
        start = 1'b0;
      end
      wait_idle();
      step($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
